// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: store-size encodings, MEM-stage FSM states
// and data-bus widths.
package riscv_pkg;

    localparam int BUS_AW  = 32;
    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = BUS_DW / 8;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane decode for a data-memory access: enables, lane-replicated store
// data and a misalignment flag from access size and the low address bits.
module mem_lane_gen
    import riscv_pkg::*;
(
    input  logic [1:0]         size_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [BUS_DW-1:0]  wdata_i,
    output logic [BUS_BEW-1:0] be_o,
    output logic [BUS_DW-1:0]  wdata_o,
    output logic               misaligned_o
);

    always_comb begin
        be_o         = 4'b1111;
        wdata_o      = wdata_i;
        misaligned_o = (addr_lo_i != 2'b00);
        case (size_i)
            MW_BYTE: begin
                be_o         = 4'b0001 << addr_lo_i;
                wdata_o      = {4{wdata_i[7:0]}};
                misaligned_o = 1'b0;
            end
            MW_HALF: begin
                be_o         = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o      = {2{wdata_i[15:0]}};
                misaligned_o = addr_lo_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_controller.sv
// MEM-stage controller: issues the EX/MEM access on a valid/ready data bus,
// stalls the upstream pipeline until completion, misalignment or timeout.
module mem_stage_controller
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_read_i,
    input  logic [1:0]         mem_write_i,
    input  logic [BUS_AW-1:0]  addr_i,
    input  logic [BUS_DW-1:0]  wdata_i,
    output logic               stall_o,
    output logic [BUS_DW-1:0]  rdata_o,
    output logic               rdata_valid_o,
    output logic               misaligned_o,
    output logic               timeout_o,
    output logic               bus_valid_o,
    output logic               bus_we_o,
    output logic [BUS_AW-1:0]  bus_addr_o,
    output logic [BUS_DW-1:0]  bus_wdata_o,
    output logic [BUS_BEW-1:0] bus_be_o,
    input  logic               bus_ready_i,
    input  logic [BUS_DW-1:0]  bus_rdata_i
);

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

    mem_state_e         state_q, state_d;
    logic               bus_valid_q, bus_valid_d;
    logic               bus_we_q, bus_we_d;
    logic [BUS_AW-1:0]  bus_addr_q, bus_addr_d;
    logic [BUS_DW-1:0]  bus_wdata_q, bus_wdata_d;
    logic [BUS_BEW-1:0] bus_be_q, bus_be_d;
    logic [BUS_DW-1:0]  rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               misaligned_q, misaligned_d;
    logic               timeout_q, timeout_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               op;
    logic               is_store;
    logic [1:0]         lane_size;
    logic [BUS_BEW-1:0] lane_be;
    logic [BUS_DW-1:0]  lane_wdata;
    logic               lane_misaligned;
    logic               timeout_hit;

    // A store wins over a simultaneous load; loads use the word lane pattern.
    assign is_store  = (mem_write_i != MW_NONE);
    assign op        = mem_read_i | is_store;
    assign lane_size = is_store ? mem_write_i : MW_WORD;

    mem_lane_gen u_lane_gen (
        .size_i       (lane_size),
        .addr_lo_i    (addr_i[1:0]),
        .wdata_i      (wdata_i),
        .be_o         (lane_be),
        .wdata_o      (lane_wdata),
        .misaligned_o (lane_misaligned)
    );

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));

    // Low in DONE so the pipeline advances exactly once per access.
    assign stall_o = ((state_q == IDLE) && op) || (state_q == BUSY);

    always_comb begin
        state_d       = state_q;
        bus_valid_d   = bus_valid_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        bus_be_d      = bus_be_q;
        rdata_d       = rdata_q;
        rdata_valid_d = rdata_valid_q;
        misaligned_d  = misaligned_q;
        timeout_d     = timeout_q;
        timer_d       = timer_q;
        case (state_q)
            IDLE: begin
                if (op && lane_misaligned) begin
                    state_d      = DONE;
                    misaligned_d = 1'b1;
                end else if (op) begin
                    state_d     = BUSY;
                    bus_valid_d = 1'b1;
                    bus_we_d    = is_store;
                    bus_addr_d  = {addr_i[BUS_AW-1:2], 2'b00};
                    bus_wdata_d = lane_wdata;
                    bus_be_d    = lane_be;
                    timer_d     = '0;
                end
            end
            BUSY: begin
                // Completion takes priority over a coincident timeout.
                if (bus_ready_i) begin
                    state_d     = DONE;
                    bus_valid_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d       = bus_rdata_i;
                        rdata_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_d     = DONE;
                    bus_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: begin
                state_d       = IDLE;
                misaligned_d  = 1'b0;
                timeout_d     = 1'b0;
                rdata_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_wdata_q   <= '0;
            bus_be_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            timeout_q     <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            bus_valid_q   <= bus_valid_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_be_q      <= bus_be_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            misaligned_q  <= misaligned_d;
            timeout_q     <= timeout_d;
            timer_q       <= timer_d;
        end
    end

    assign bus_valid_o   = bus_valid_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign bus_be_o      = bus_be_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign misaligned_o  = misaligned_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_mem_stage_controller.sv
// Directed, table-driven bench for mem_stage_controller with hand-computed
// expectations, plus a mid-access reset sequence.
module tb_mem_stage_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_i;
    logic [1:0]  mem_write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        misaligned_o;
    logic        timeout_o;
    logic        bus_valid_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;

    int total = 0;
    int bad   = 0;

    mem_stage_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_read_i    (mem_read_i),
        .mem_write_i   (mem_write_i),
        .addr_i        (addr_i),
        .wdata_i       (wdata_i),
        .stall_o       (stall_o),
        .rdata_o       (rdata_o),
        .rdata_valid_o (rdata_valid_o),
        .misaligned_o  (misaligned_o),
        .timeout_o     (timeout_o),
        .bus_valid_o   (bus_valid_o),
        .bus_we_o      (bus_we_o),
        .bus_addr_o    (bus_addr_o),
        .bus_wdata_o   (bus_wdata_o),
        .bus_be_o      (bus_be_o),
        .bus_ready_i   (bus_ready_i),
        .bus_rdata_i   (bus_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic [1:0]  mw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          k;       // ready in the k-th valid cycle; 0 = never
        logic [31:0] rdata;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_we;
        logic        e_mis;
        logic        e_to;
        int          e_stall;
        logic [31:0] e_rdata;
        logic        e_rv;
    } rec_t;

    rec_t vec[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input rec_t r, input int idx);
        int  stall_cnt;
        int  bv;
        int  e_bv;
        bit  done;
        e_bv = r.e_mis ? 0 : ((r.k == 0) ? 16 : r.k);
        @(posedge clk);
        #1;
        mem_read_i  = r.rd;
        mem_write_i = r.mw;
        addr_i      = r.addr;
        wdata_i     = r.wdata;
        bus_ready_i = 1'b0;
        stall_cnt   = 0;
        bv          = 0;
        done        = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall_o) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                chk($sformatf("v%0d stall_cycles", idx), stall_cnt, r.e_stall);
                chk($sformatf("v%0d valid_cycles", idx), bv, e_bv);
                chk($sformatf("v%0d done_misaligned", idx), misaligned_o, r.e_mis);
                chk($sformatf("v%0d done_timeout", idx), timeout_o, r.e_to);
                chk($sformatf("v%0d done_rdata_valid", idx), rdata_valid_o, r.e_rv);
                chk($sformatf("v%0d done_rdata", idx), rdata_o, r.e_rdata);
                chk($sformatf("v%0d done_bus_valid", idx), bus_valid_o, 1'b0);
                mem_read_i  = 1'b0;
                mem_write_i = 2'b00;
                bus_ready_i = 1'b0;
            end
            if (!done && bus_valid_o) begin
                bv++;
                chk($sformatf("v%0d bus_addr", idx), bus_addr_o, r.e_addr);
                chk($sformatf("v%0d bus_be", idx), bus_be_o, r.e_be);
                chk($sformatf("v%0d bus_wdata", idx), bus_wdata_o, r.e_wdata);
                chk($sformatf("v%0d bus_we", idx), bus_we_o, r.e_we);
                // EX/MEM inputs wander while BUSY; bus outputs must not follow.
                addr_i      = ~r.addr;
                wdata_i     = r.wdata ^ 32'h5A5A_0F0F;
                bus_ready_i = (r.k != 0) && (bv == r.k);
                bus_rdata_i = bus_ready_i ? r.rdata : 32'hBAD0_BAD0;
            end else if (!done) begin
                bus_ready_i = 1'b0;
            end
        end
        if (!done) begin
            chk($sformatf("v%0d access_never_finished", idx), 32'd0, 32'd1);
            mem_read_i  = 1'b0;
            mem_write_i = 2'b00;
            bus_ready_i = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("v%0d after_rdata_valid", idx), rdata_valid_o, 1'b0);
        chk($sformatf("v%0d after_misaligned", idx), misaligned_o, 1'b0);
        chk($sformatf("v%0d after_timeout", idx), timeout_o, 1'b0);
        chk($sformatf("v%0d after_rdata_held", idx), rdata_o, r.e_rdata);
        chk($sformatf("v%0d after_stall", idx), stall_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec_t r;
        //           rd  mw     addr          wdata         k  rdata         e_addr        e_be   e_wdata       we mis to st e_rdata       rv
        vec[0]  = '{1'b0, 2'b11, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'h0,        32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1, 0, 0, 3,  32'h0,         0};
        vec[1]  = '{1'b0, 2'b01, 32'h0000_0203, 32'h0000_00A5, 1, 32'h0,        32'h0000_0200, 4'h8, 32'hA5A5_A5A5, 1, 0, 0, 2,  32'h0,         0};
        vec[2]  = '{1'b0, 2'b10, 32'h0000_0202, 32'h0000_1234, 3, 32'h0,        32'h0000_0200, 4'hC, 32'h1234_1234, 1, 0, 0, 4,  32'h0,         0};
        vec[3]  = '{1'b1, 2'b00, 32'h0000_0040, 32'h0000_0000, 1, 32'hCAFE_F00D, 32'h0000_0040, 4'hF, 32'h0000_0000, 0, 0, 0, 2,  32'hCAFE_F00D, 1};
        vec[4]  = '{1'b0, 2'b11, 32'h0000_0102, 32'h1111_1111, 0, 32'h0,        32'h0,         4'h0, 32'h0,         0, 1, 0, 1,  32'hCAFE_F00D, 0};
        vec[5]  = '{1'b0, 2'b10, 32'h0000_0101, 32'h2222_2222, 0, 32'h0,        32'h0,         4'h0, 32'h0,         0, 1, 0, 1,  32'hCAFE_F00D, 0};
        vec[6]  = '{1'b0, 2'b01, 32'h0000_0001, 32'hFFFF_FF3C, 1, 32'h0,        32'h0000_0000, 4'h2, 32'h3C3C_3C3C, 1, 0, 0, 2,  32'hCAFE_F00D, 0};
        vec[7]  = '{1'b0, 2'b10, 32'h0000_0200, 32'hABCD_5678, 1, 32'h0,        32'h0000_0200, 4'h3, 32'h5678_5678, 1, 0, 0, 2,  32'hCAFE_F00D, 0};
        vec[8]  = '{1'b1, 2'b00, 32'h0000_0041, 32'h0,         0, 32'h0,        32'h0,         4'h0, 32'h0,         0, 1, 0, 1,  32'hCAFE_F00D, 0};
        vec[9]  = '{1'b1, 2'b01, 32'h0000_0012, 32'h0000_0077, 2, 32'h0,        32'h0000_0010, 4'h4, 32'h7777_7777, 1, 0, 0, 3,  32'hCAFE_F00D, 0};
        vec[10] = '{1'b1, 2'b00, 32'h0000_0080, 32'h55AA_55AA, 0, 32'h0,        32'h0000_0080, 4'hF, 32'h55AA_55AA, 0, 0, 1, 17, 32'hCAFE_F00D, 0};
        vec[11] = '{1'b1, 2'b00, 32'h0000_0084, 32'h0,         4, 32'h1357_9BDF, 32'h0000_0084, 4'hF, 32'h0,         0, 0, 0, 5,  32'h1357_9BDF, 1};

        reset       = 1'b1;
        mem_read_i  = 1'b0;
        mem_write_i = 2'b00;
        addr_i      = '0;
        wdata_i     = '0;
        bus_ready_i = 1'b0;
        bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_bus_valid", bus_valid_o, 1'b0);
        chk("reset_bus_we", bus_we_o, 1'b0);
        chk("reset_bus_addr", bus_addr_o, 32'h0);
        chk("reset_bus_wdata", bus_wdata_o, 32'h0);
        chk("reset_bus_be", bus_be_o, 4'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        chk("reset_flags", {rdata_valid_o, misaligned_o, timeout_o, stall_o}, 4'b0000);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) run_access(vec[i], i);

        // Reset two cycles into BUSY of a load that is never acknowledged.
        @(posedge clk);
        #1;
        mem_read_i = 1'b1;
        addr_i     = 32'h0000_0044;
        @(negedge clk);
        chk("rst_seq_idle_stall", stall_o, 1'b1);
        @(negedge clk);
        chk("rst_seq_busy1_valid", bus_valid_o, 1'b1);
        @(negedge clk);
        chk("rst_seq_busy2_valid", bus_valid_o, 1'b1);
        reset = 1'b1;
        #1;
        chk("rst_seq_bus_valid", bus_valid_o, 1'b0);
        chk("rst_seq_bus_addr", bus_addr_o, 32'h0);
        chk("rst_seq_bus_be", bus_be_o, 4'h0);
        chk("rst_seq_bus_we", bus_we_o, 1'b0);
        chk("rst_seq_rdata", rdata_o, 32'h0);
        chk("rst_seq_stall_op", stall_o, 1'b1);
        mem_read_i = 1'b0;
        #1;
        chk("rst_seq_stall_noop", stall_o, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        r = vec[0];
        r.e_rdata = 32'h0;
        run_access(r, 100);
        run_access(vec[3], 103);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_controller.md
Name: mem_stage_controller

Overview:
Sequences every MEM-stage data-memory access held in the EX/MEM pipeline register onto a multi-cycle valid/ready memory bus.
- Generates byte lanes and write-data replication for SB/SH/SW.
- Detects misalignment and bounds each access with a timeout.
- Asserts stall_o to freeze the PC, IF/ID, ID/EX and EX/MEM registers until the access completes.
- Sits between the EX/MEM register outputs and the data-memory bus. rdata_o feeds the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 16, cycles in BUSY without bus_ready_i before the access is aborted; 0 disables the timeout.

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
mem_read_i  input  1  load request (word) from EX/MEM
mem_write_i  input  2  store size from EX/MEM: 00 none, 01 byte, 10 half, 11 word
addr_i  input  32  byte address (EX/MEM alu_result)
wdata_i  input  32  store data (EX/MEM rdata2)
stall_o  output  1  freeze upstream pipeline registers
rdata_o  output  32  last completed load data
rdata_valid_o  output  1  one-cycle pulse when rdata_o is updated
misaligned_o  output  1  access rejected for misalignment (held during DONE)
timeout_o  output  1  access aborted by timeout (held during DONE)
bus_valid_o  output  1  bus request
bus_we_o  output  1  1 = write
bus_addr_o  output  32  word address {addr[31:2],2'b00}
bus_wdata_o  output  32  lane-replicated write data
bus_be_o  output  4  byte enables
bus_ready_i  input  1  bus completion
bus_rdata_i  input  32  bus read data, valid with bus_ready_i

Behaviour:
- Operation present: op = mem_read_i | (mem_write_i != 00). If both a read and a write are present, the write wins and is treated as a store.
- Byte lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata_i[15:0]}}.
  - SW and loads: be = 4'b1111; wdata = wdata_i.
- Misalignment: SH with addr[0]=1; SW or load with addr[1:0]!=00. SB is never misaligned.
- FSM states IDLE, BUSY, DONE. All outputs are registered except stall_o.
- IDLE:
  - op && !misaligned -> BUSY. Latch bus_addr/we/be/wdata and set bus_valid_o=1 on the next edge. Clear timer.
  - op && misaligned -> DONE. misaligned_o<=1; no bus access is issued.
  - No op -> stay in IDLE.
- BUSY:
  - bus_valid_o and all bus_* outputs stay stable. EX/MEM input changes are ignored.
  - bus_ready_i -> DONE, bus_valid_o<=0. For a read, rdata_o<=bus_rdata_i and rdata_valid_o<=1.
  - Otherwise timer++. When TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 with no ready: -> DONE, timeout_o<=1, bus_valid_o<=0, rdata_o unchanged.
  - bus_ready_i on the same cycle as the timeout limit: completion wins.
- DONE: lasts one cycle, then -> IDLE. On exit, misaligned_o, timeout_o and rdata_valid_o clear.
- stall_o = (state==IDLE && op) || state==BUSY. It is low in DONE so the pipeline advances exactly once per access.
- Latency: an access acknowledged k cycles after bus_valid_o rises stalls for k+1 cycles (k>=1). A misaligned access stalls for 1 cycle.
- rdata_o holds its value until the next completed read.
- Back-to-back accesses: IDLE is re-entered after DONE, so at least one idle-bus cycle separates requests.
- Reset (any time, including mid-BUSY): state=IDLE, bus_valid_o=0, bus_we_o=0, bus_be_o=0, bus_addr_o=0, bus_wdata_o=0, rdata_o=0, rdata_valid_o=0, misaligned_o=0, timeout_o=0, timer=0. stall_o follows the inputs combinationally.

Decomposition:
- Shared package (riscv_pkg):
  - mem_write encodings MW_NONE/MW_BYTE/MW_HALF/MW_WORD
  - FSM state enum {IDLE,BUSY,DONE}
  - bus width constants
- Sub-module mem_lane_gen (combinational): computes be, replicated wdata and misaligned from size and addr[1:0]. It is reused by the future load-extend unit.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, bus_ready_i 2 cycles after bus_valid_o -> bus_addr=0x100, be=1111, we=1, stall_o high 3 cycles, low in DONE.
- SB addr=0x203, wdata=0x000000A5 -> be=1000, bus_wdata=0xA5A5A5A5; SH addr=0x202, wdata=0x1234 -> be=1100, bus_wdata=0x12341234.
- LW addr=0x40, bus_rdata_i=0xCAFEF00D with ready after 1 cycle -> rdata_o=0xCAFEF00D, rdata_valid_o pulses 1 cycle, rdata_o held afterwards.
- SW addr=0x102 -> no bus_valid_o, misaligned_o=1 for 1 cycle, stall_o 1 cycle; SH addr=0x101 gives the same result.
- LW with bus_ready_i never asserted, TIMEOUT_CYCLES=16 -> bus_valid_o drops after 16 cycles, timeout_o=1, stall_o releases, rdata_o unchanged.
- Reset asserted 2 cycles into BUSY -> bus_valid_o=0 immediately, all outputs at reset values, FSM in IDLE; a new access issues normally after reset release.
